// File: rtl/uart_pkg.sv
// Shared types for the UART transmit-side arbiter: frame config payload,
// its reset value, and the arbiter state encoding.
package uart_pkg;

  localparam int unsigned CFG_BITS_W = 2;
  localparam int unsigned CFG_BAUD_W = 2;
  localparam int unsigned LOCK_CNT_W = 16;

  typedef struct packed {
    logic                  parity;
    logic [CFG_BITS_W-1:0] bits;
    logic [CFG_BAUD_W-1:0] baud;
  } cfg_t;

  localparam cfg_t CFG_RST = '{parity: 1'b0, bits: 2'b11, baud: 2'b00};

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_HOLD      = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin pick: first set bit of req, searching upward
// from index base and wrapping modulo N.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] base,
  output logic [IDX_W-1:0] idx_c,
  output logic             found_c
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    idx_c   = '0;
    found_c = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IDX_W'((32'(base) + i) % N);
      if (!found_c && req[cand]) begin
        found_c = 1'b1;
        idx_c   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin sequencer sharing one uart_tx among NUM_REQ byte streams,
// with per-packet grant lock, idle-lock timeout and frame-config shadowing.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]            i_req_last,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic                          i_cfg_parity,
  input  logic [1:0]                    i_cfg_bits,
  input  logic [1:0]                    i_cfg_baud,
  output logic                          o_tx_en,
  output logic [DATA_WIDTH-1:0]         o_tx_data,
  output logic                          o_cfg_parity,
  output logic [1:0]                    o_cfg_bits,
  output logic [1:0]                    o_cfg_baud,
  input  logic                          i_tx_busy,
  input  logic                          i_tx_done,
  output logic [$clog2(NUM_REQ)-1:0]    o_grant_id,
  output logic                          o_locked,
  output logic                          o_lock_timeout
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [LOCK_CNT_W-1:0] CNT_LAST = LOCK_CNT_W'(LOCK_TIMEOUT - 1);

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [NUM_REQ-1:0]      ready_q, ready_d;
  logic                    tx_en_q, tx_en_d;
  logic                    last_q, last_d;
  logic                    locked_q, locked_d;
  logic                    tmo_q, tmo_d;
  cfg_t                    cfg_q, cfg_d;
  logic [LOCK_CNT_W-1:0]   cnt_q, cnt_d;

  logic [IDX_W-1:0]        base_c;
  logic [IDX_W-1:0]        pick_idx_c;
  logic                    pick_found_c;
  logic [DATA_WIDTH-1:0]   pick_data_c;
  logic [DATA_WIDTH-1:0]   owner_data_c;

  // Rotation resumes just past the current/last owner.
  assign base_c       = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);
  assign pick_data_c  = i_req_data[32'(pick_idx_c) * DATA_WIDTH +: DATA_WIDTH];
  assign owner_data_c = i_req_data[32'(grant_q) * DATA_WIDTH +: DATA_WIDTH];

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req     (i_req_valid),
    .base    (base_c),
    .idx_c   (pick_idx_c),
    .found_c (pick_found_c)
  );

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= LAST_IDX;
      data_q   <= '0;
      ready_q  <= '0;
      tx_en_q  <= 1'b0;
      last_q   <= 1'b0;
      locked_q <= 1'b0;
      tmo_q    <= 1'b0;
      cfg_q    <= CFG_RST;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      ready_q  <= ready_d;
      tx_en_q  <= tx_en_d;
      last_q   <= last_d;
      locked_q <= locked_d;
      tmo_q    <= tmo_d;
      cfg_q    <= cfg_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    data_d   = data_q;
    ready_d  = '0;
    tx_en_d  = 1'b0;
    last_d   = last_q;
    locked_d = locked_q;
    tmo_d    = tmo_q;
    cfg_d    = cfg_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        cfg_d = '{parity: i_cfg_parity, bits: i_cfg_bits, baud: i_cfg_baud};
        if (pick_found_c && !i_tx_busy) begin
          ready_d[pick_idx_c] = 1'b1;
          data_d              = pick_data_c;
          last_d              = i_req_last[pick_idx_c];
          grant_d             = pick_idx_c;
          state_d             = ST_LAUNCH;
        end
      end

      ST_LAUNCH: begin
        tx_en_d = 1'b1;
        state_d = ST_WAIT_DONE;
      end

      ST_WAIT_DONE: begin
        if (i_tx_done) begin
          if (last_q) begin
            locked_d = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            locked_d = 1'b1;
            cnt_d    = '0;
            state_d  = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        // Timeout takes precedence over a byte arriving in the same cycle.
        if (cnt_q == CNT_LAST) begin
          cnt_d    = cnt_q + LOCK_CNT_W'(1);
          locked_d = 1'b0;
          tmo_d    = 1'b1;
          state_d  = ST_IDLE;
        end else if (i_req_valid[grant_q] && !i_tx_busy) begin
          ready_d[grant_q] = 1'b1;
          data_d           = owner_data_c;
          last_d           = i_req_last[grant_q];
          cnt_d            = '0;
          state_d          = ST_LAUNCH;
        end else begin
          cnt_d = cnt_q + LOCK_CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign o_req_ready    = ready_q;
  assign o_tx_en        = tx_en_q;
  assign o_tx_data      = data_q;
  assign o_cfg_parity   = cfg_q.parity;
  assign o_cfg_bits     = cfg_q.bits;
  assign o_cfg_baud     = cfg_q.baud;
  assign o_grant_id     = grant_q;
  assign o_locked       = locked_q;
  assign o_lock_timeout = tmo_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: tests push expected launches, a negedge
// monitor pops and checks every o_tx_en against them.
module tb_uart_tx_arb;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned TMO  = 16;
  localparam int unsigned UART_CYC = 6;

  typedef struct {
    int          id;
    logic [7:0]  data;
    logic        locked;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    i_req_valid;
  logic [NREQ*DW-1:0] i_req_data;
  logic [NREQ-1:0]    i_req_last;
  logic [NREQ-1:0]    o_req_ready;
  logic               i_cfg_parity;
  logic [1:0]         i_cfg_bits;
  logic [1:0]         i_cfg_baud;
  logic               o_tx_en;
  logic [DW-1:0]      o_tx_data;
  logic               o_cfg_parity;
  logic [1:0]         o_cfg_bits;
  logic [1:0]         o_cfg_baud;
  logic               i_tx_busy;
  logic               i_tx_done;
  logic [1:0]         o_grant_id;
  logic               o_locked;
  logic               o_lock_timeout;

  logic               rv [NREQ];
  logic [DW-1:0]      rd [NREQ];
  logic               rl [NREQ];

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_ready_cyc = -100;
  int   n_tx = 0;
  int   n_done = 0;
  logic prev_tx_en = 1'b0;

  uart_tx_arb #(
    .NUM_REQ      (NREQ),
    .DATA_WIDTH   (DW),
    .LOCK_TIMEOUT (TMO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_req_valid    (i_req_valid),
    .i_req_data     (i_req_data),
    .i_req_last     (i_req_last),
    .o_req_ready    (o_req_ready),
    .i_cfg_parity   (i_cfg_parity),
    .i_cfg_bits     (i_cfg_bits),
    .i_cfg_baud     (i_cfg_baud),
    .o_tx_en        (o_tx_en),
    .o_tx_data      (o_tx_data),
    .o_cfg_parity   (o_cfg_parity),
    .o_cfg_bits     (o_cfg_bits),
    .o_cfg_baud     (o_cfg_baud),
    .i_tx_busy      (i_tx_busy),
    .i_tx_done      (i_tx_done),
    .o_grant_id     (o_grant_id),
    .o_locked       (o_locked),
    .o_lock_timeout (o_lock_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int r = 0; r < NREQ; r++) begin
      i_req_valid[r]          = rv[r];
      i_req_data[r*DW +: DW]  = rd[r];
      i_req_last[r]           = rl[r];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Simple uart_tx stand-in: busy for UART_CYC cycles after tx_en, then a done pulse.
  initial begin
    i_tx_busy = 1'b0;
    i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && o_tx_en) begin
        #1 i_tx_busy = 1'b1;
        for (int k = 0; k < UART_CYC && rst_n; k++) @(negedge clk);
        #1;
        if (rst_n) begin
          i_tx_done = 1'b1;
          n_done++;
          @(negedge clk);
          #1;
        end
        i_tx_done = 1'b0;
        i_tx_busy = 1'b0;
      end
    end
  end

  // Monitor: ready is one-hot, tx_en is a single-cycle pulse one cycle after
  // ready, never while busy, and matches the next scoreboard entry.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (o_req_ready != '0) begin
        chk("ready_onehot", 32'($onehot(o_req_ready)), 32'd1);
        last_ready_cyc = cyc;
      end
      if (o_tx_en) begin
        n_tx++;
        chk("tx_en_latency", 32'(cyc - last_ready_cyc), 32'd1);
        chk("tx_en_while_busy", 32'(i_tx_busy), 32'd0);
        chk("tx_en_single_cycle", 32'(prev_tx_en), 32'd0);
        if (exp_q.size() == 0) begin
          chk("spurious_tx_en", 32'(n_tx), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("tx_data", 32'(o_tx_data), 32'(e.data));
          chk("grant_id", 32'(o_grant_id), 32'(e.id));
          chk("locked_at_tx", 32'(o_locked), 32'(e.locked));
        end
      end
      prev_tx_en = o_tx_en;
    end else begin
      prev_tx_en = 1'b0;
    end
  end

  task automatic push(input int id, input logic [7:0] d, input logic lk);
    exp_t e;
    e.id = id; e.data = d; e.locked = lk;
    exp_q.push_back(e);
  endtask

  task automatic send(input int r, input logic [7:0] d, input logic last);
    bit got;
    got = 1'b0;
    rv[r] = 1'b1; rd[r] = d; rl[r] = last;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (o_req_ready[r]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk($sformatf("ready_timeout_req%0d", r), 32'd0, 32'd1);
    @(posedge clk);
    #1 rv[r] = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !i_tx_busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int r = 0; r < NREQ; r++) begin
      rv[r] = 1'b0; rd[r] = '0; rl[r] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_tx_en"},   32'(o_tx_en), 32'd0);
    chk({tag, "_tx_data"}, 32'(o_tx_data), 32'd0);
    chk({tag, "_ready"},   32'(o_req_ready), 32'd0);
    chk({tag, "_grant"},   32'(o_grant_id), 32'd3);
    chk({tag, "_locked"},  32'(o_locked), 32'd0);
    chk({tag, "_tmo"},     32'(o_lock_timeout), 32'd0);
    chk({tag, "_cfg"},     32'({o_cfg_parity, o_cfg_bits, o_cfg_baud}), 32'b0_11_00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx0, d0, n;
    bit seen;
    rst_n = 1'b0;
    i_cfg_parity = 1'b0; i_cfg_bits = 2'b11; i_cfg_baud = 2'b00;
    for (int r = 0; r < NREQ; r++) begin
      rv[r] = 1'b0; rd[r] = '0; rl[r] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte from requester 1.
    push(1, 8'hA5, 1'b0);
    send(1, 8'hA5, 1'b1);
    drain();
    chk("single_grant", 32'(o_grant_id), 32'd1);
    chk("single_locked", 32'(o_locked), 32'd0);

    // Fairness: all four valid, grant order 0,1,2,3,0.
    apply_reset();
    tx0 = n_tx; d0 = n_done;
    push(0, 8'h10, 1'b0); push(1, 8'h21, 1'b0); push(2, 8'h32, 1'b0);
    push(3, 8'h43, 1'b0); push(0, 8'h14, 1'b0);
    fork
      begin send(0, 8'h10, 1'b1); send(0, 8'h14, 1'b1); end
      send(1, 8'h21, 1'b1);
      send(2, 8'h32, 1'b1);
      send(3, 8'h43, 1'b1);
    join
    drain();
    chk("fair_tx_count", 32'(n_tx - tx0), 32'd5);
    chk("fair_done_count", 32'(n_done - d0), 32'd5);

    // Packet lock: req2 three-byte packet, req0 waits until it completes.
    apply_reset();
    push(2, 8'h11, 1'b0); push(2, 8'h22, 1'b1); push(2, 8'h33, 1'b1);
    push(0, 8'h44, 1'b0);
    fork
      begin send(2, 8'h11, 1'b0); send(2, 8'h22, 1'b0); send(2, 8'h33, 1'b1); end
      begin
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (o_req_ready[2]) begin seen = 1'b1; break; end
        end
        if (!seen) chk("lock_first_ready", 32'd0, 32'd1);
        send(0, 8'h44, 1'b1);
      end
    join
    drain();
    chk("lock_released", 32'(o_locked), 32'd0);

    // Lock timeout: req3 sends last=0 then goes quiet; req0/req1 pending.
    apply_reset();
    push(3, 8'h55, 1'b0); push(0, 8'h66, 1'b0); push(1, 8'h77, 1'b0);
    send(3, 8'h55, 1'b0);
    fork
      send(0, 8'h66, 1'b1);
      send(1, 8'h77, 1'b1);
    join_none
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (o_locked) begin seen = 1'b1; break; end
    end
    chk("tmo_lock_set", 32'(seen), 32'd1);
    n = 0;
    while (o_locked && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_hold_cycles", 32'(n), 32'(TMO));
    chk("tmo_sticky", 32'(o_lock_timeout), 32'd1);
    wait fork;
    drain();
    chk("tmo_still_sticky", 32'(o_lock_timeout), 32'd1);

    // Config shadow: baud change during WAIT_DONE takes effect only after IDLE.
    push(2, 8'h99, 1'b0);
    fork
      send(2, 8'h99, 1'b1);
      begin
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
          @(posedge clk);
          if (i_tx_busy) begin seen = 1'b1; break; end
        end
        #1 i_cfg_baud = 2'b10;
        @(negedge clk);
        chk("cfg_frozen_wait", 32'(o_cfg_baud), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
          @(posedge clk);
          if (i_tx_done) begin seen = 1'b1; break; end
        end
        chk("cfg_done_seen", 32'(seen), 32'd1);
        @(negedge clk);
        chk("cfg_first_idle", 32'(o_cfg_baud), 32'd0);
        @(negedge clk);
        chk("cfg_updated", 32'(o_cfg_baud), 32'd2);
      end
    join
    drain();
    i_cfg_baud = 2'b00;

    // Reset in WAIT_DONE: outputs at reset values immediately, no tx_en after.
    push(1, 8'hC3, 1'b0);
    send(1, 8'hC3, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      if (i_tx_busy) begin seen = 1'b1; break; end
    end
    #1 rst_n = 1'b0;
    #1 check_reset_values("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tx0 = n_tx;
    repeat (20) @(negedge clk);
    chk("no_tx_after_reset", 32'(n_tx - tx0), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
